led_pattern_gen: RTL and testbench

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_gen.sv | 93 +++++++++
 tb/tb_led_pattern_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared 125 ms tick prescaler drives
// per-channel phase counters that select steady, blink or burst patterns.
module led_pattern_gen #(
  parameter int   CLK_FRQ     = 10500000,
  parameter int   NCH         = 4,
  parameter int   FRAME_TICKS = 32,
  parameter logic LED_ON      = 1'b1
) (
  input  logic               SYSCLK,
  input  logic               RESET_N,
  input  logic [3*NCH-1:0]   MODE,
  input  logic [4*NCH-1:0]   BURST_N,
  output logic [NCH-1:0]     LED,
  output logic               TICK
);

  localparam int TICK_CYC = CLK_FRQ / 8;
  localparam int PRE_W    = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int PH_W     = $clog2(FRAME_TICKS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic                      tick_q, tick_d;
  logic                      tick_cyc;
  logic [NCH-1:0][2:0]       cur_mode_q, cur_mode_d;
  logic [NCH-1:0][PH_W-1:0]  ph_q, ph_d;
  logic [NCH-1:0][3:0]       burst_q, burst_d;
  logic [NCH-1:0]            led_q, led_d;
  logic [NCH-1:0]            lit;

  always_comb begin
    tick_cyc = (pre_q == PRE_LAST);
    pre_d    = tick_cyc ? '0 : pre_q + PRE_W'(1);
    tick_d   = tick_cyc;
  end

  // Burst count is captured on the tick so mid-tick edits cannot glitch the LED.
  always_comb begin
    cur_mode_d = cur_mode_q;
    ph_d       = ph_q;
    burst_d    = burst_q;
    if (tick_cyc) begin
      for (int i = 0; i < NCH; i++) begin
        burst_d[i] = BURST_N[4*i +: 4];
        if (MODE[3*i +: 3] != cur_mode_q[i]) begin
          cur_mode_d[i] = MODE[3*i +: 3];
          ph_d[i]       = '0;
        end else begin
          ph_d[i] = ph_q[i] + PH_W'(1);
        end
      end
    end
  end

  always_comb begin
    lit   = '0;
    led_d = '0;
    for (int i = 0; i < NCH; i++) begin
      case (cur_mode_q[i])
        3'd1:    lit[i] = 1'b1;
        3'd2:    lit[i] = ~ph_q[i][2];
        3'd3:    lit[i] = ~ph_q[i][1];
        3'd4:    lit[i] = ~ph_q[i][0];
        3'd5:    lit[i] = ~ph_q[i][0] &&
                          (9'(ph_q[i]) < 9'({burst_q[i], 1'b0}));
        default: lit[i] = 1'b0;
      endcase
      led_d[i] = lit[i] ? LED_ON : ~LED_ON;
    end
  end

  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      pre_q      <= '0;
      tick_q     <= 1'b0;
      cur_mode_q <= '0;
      ph_q       <= '0;
      burst_q    <= '0;
      led_q      <= {NCH{~LED_ON}};
    end else begin
      pre_q      <= pre_d;
      tick_q     <= tick_d;
      cur_mode_q <= cur_mode_d;
      ph_q       <= ph_d;
      burst_q    <= burst_d;
      led_q      <= led_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: TICK_CYC=10, NCH=2, FRAME_TICKS=8,
// one instance lit-high and one lit-low for the async reset case.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [5:0] mode, mode2;
  logic [7:0] burst, burst2;
  logic [1:0] led, led2;
  logic       tick, tick2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int neq;
  logic [7:0] pat0, pat1;

  always #5 clk = ~clk;

  led_pattern_gen #(.CLK_FRQ(80), .NCH(2), .FRAME_TICKS(8), .LED_ON(1'b1)) u_dut (
    .SYSCLK(clk), .RESET_N(rst_n), .MODE(mode), .BURST_N(burst),
    .LED(led), .TICK(tick));

  led_pattern_gen #(.CLK_FRQ(80), .NCH(2), .FRAME_TICKS(8), .LED_ON(1'b0)) u_dut_n (
    .SYSCLK(clk), .RESET_N(rst2_n), .MODE(mode2), .BURST_N(burst2),
    .LED(led2), .TICK(tick2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    mode   = '0;
    burst  = '0;
    mode2  = {3'd1, 3'd5};
    burst2 = {4'd0, 4'd2};

    // All modes off: tick cadence and dark LEDs
    step();
    step();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_led_n", 32'(led2), 32'd3);
    rst_n = 1'b1;
    cyc = 0;
    goto(9);
    check("tick_c9", 32'(tick), 32'd0);
    goto(10);
    check("tick_c10", 32'(tick), 32'd1);
    check("off_led_c10", 32'(led), 32'd0);
    goto(11);
    check("tick_c11", 32'(tick), 32'd0);
    goto(20);
    check("tick_c20", 32'(tick), 32'd1);
    goto(31);
    check("off_led_c31", 32'(led), 32'd0);

    // 4 Hz on ch0 selected before the first tick
    mode = {3'd0, 3'd4};
    do_reset();
    goto(10);
    check("hz4_c10", 32'(led), 32'd0);
    goto(11);
    check("hz4_c11", 32'(led), 32'd1);
    goto(20);
    check("hz4_c20", 32'(led), 32'd1);
    goto(21);
    check("hz4_c21", 32'(led), 32'd0);
    goto(31);
    check("hz4_c31", 32'(led), 32'd1);

    // Burst: ch0 N=2 lights PH 0,2; ch1 N=15 saturates to plain 4 Hz
    mode  = {3'd5, 3'd5};
    burst = {4'd15, 4'd2};
    pat0  = 8'b0000_0101;
    pat1  = 8'b0101_0101;
    do_reset();
    for (int j = 0; j < 9; j++) begin
      goto(11 + 10*j);
      check($sformatf("burst_ch0_ph%0d", j % 8), 32'(led[0]), 32'(pat0[j % 8]));
      check($sformatf("burst_ch1_ph%0d", j % 8), 32'(led[1]), 32'(pat1[j % 8]));
    end
    burst = {4'd15, 4'd0};
    goto(95);
    check("burst_hold_c95", 32'(led[0]), 32'd1);
    goto(111);
    check("burst_n0_ch0", 32'(led[0]), 32'd0);
    check("burst_n0_ch1", 32'(led[1]), 32'd1);

    // 1 Hz on both channels, ch1 rewritten with the same mode mid-frame
    mode  = {3'd2, 3'd2};
    burst = '0;
    do_reset();
    goto(10);
    check("hz1_c10", 32'(led), 32'd0);
    goto(11);
    check("hz1_c11", 32'(led), 32'd3);
    goto(45);
    mode = {3'd2, 3'd2};
    goto(50);
    check("hz1_c50", 32'(led), 32'd3);
    goto(51);
    check("hz1_c51", 32'(led), 32'd0);
    goto(81);
    check("hz1_c81", 32'(led), 32'd0);
    goto(91);
    check("hz1_c91", 32'(led), 32'd3);
    neq = 0;
    for (int c = 92; c <= 170; c++) begin
      goto(c);
      if (led[0] !== led[1]) neq++;
    end
    check("hz1_lockstep", 32'(neq), 32'd0);
    check("hz1_c170", 32'(led), 32'd0);

    // 2 Hz with a transient mode change that is gone before the next tick
    mode  = {3'd0, 3'd3};
    burst = {4'd0, 4'd15};
    do_reset();
    goto(31);
    check("hz2_c31", 32'(led[0]), 32'd0);
    goto(33);
    mode = {3'd0, 3'd5};
    goto(36);
    check("hz2_transient", 32'(led[0]), 32'd0);
    goto(37);
    mode = {3'd0, 3'd3};
    goto(40);
    check("hz2_tick_c40", 32'(tick), 32'd1);
    goto(41);
    check("hz2_c41", 32'(led[0]), 32'd0);
    goto(51);
    check("hz2_c51", 32'(led[0]), 32'd1);
    goto(71);
    check("hz2_c71", 32'(led[0]), 32'd0);

    // Active-low LEDs, reset pulsed mid-burst
    rst2_n = 1'b1;
    cyc = 0;
    goto(11);
    check("n_c11", 32'(led2), 32'd0);
    goto(25);
    check("n_c25", 32'(led2), 32'd1);
    #4;
    rst2_n = 1'b0;
    #1;
    check("n_async_led", 32'(led2), 32'd3);
    check("n_async_tick", 32'(tick2), 32'd0);
    @(posedge clk);
    #1;
    rst2_n = 1'b1;
    cyc = 0;
    goto(9);
    check("n_tick_c9", 32'(tick2), 32'd0);
    goto(10);
    check("n_tick_c10", 32'(tick2), 32'd1);
    check("n_led_c10", 32'(led2), 32'd3);
    goto(11);
    check("n_led_c11", 32'(led2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
